// File: rtl/wb_pkg.sv
// Shared constants and types for the integer register-file writeback path.
package wb_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            we;
    } wb_req_t;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_LL   = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending bits for long-latency destinations; register 0 is never pending.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [AW-1:0]    set_idx,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_idx,
    input  logic [AW-1:0]    q_idx_a,
    input  logic [AW-1:0]    q_idx_b,
    output logic             busy_a,
    output logic             busy_b,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_p0;
    logic [NREGS-1:0] busy_nxt;

    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    always_comb begin
        busy_nxt = busy_p0;
        if (clr_en) begin
            busy_nxt[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != '0)) begin
            busy_nxt[set_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_p0 <= '0;
        end else begin
            busy_p0 <= busy_nxt;
        end
    end

    assign busy_a   = (q_idx_a != '0) && busy_p0[q_idx_a];
    assign busy_b   = (q_idx_b != '0) && busy_p0[q_idx_b];
    assign busy_vec = busy_p0;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges in-order pipeline results and buffered long-latency results onto the
// single register-file write port, with a pending scoreboard for issue stalls.
module writeback_arbiter
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            p_valid,
    output logic            p_ready,
    input  logic [AW-1:0]   p_rd,
    input  logic [XLEN-1:0] p_data,
    input  logic            p_wen,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [AW-1:0]   ll_rd,
    input  logic [XLEN-1:0] ll_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   q_rs1,
    input  logic [AW-1:0]   q_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_we,
    output logic            retire
);

    logic            hold_vld_p0;
    logic [AW-1:0]   hold_rd_p0;
    logic [XLEN-1:0] hold_data_p0;
    logic            starve_p0;

    logic            hold_grant;
    logic            p_acc;
    logic            ll_acc;
    logic            grant_any;
    wb_req_t         sel_req;
    wb_src_e         sel_src;

    logic            wb_we_p1;
    logic            retire_p1;
    logic [AW-1:0]   wb_rd_p1;
    logic [XLEN-1:0] wb_data_p1;
    wb_src_e         wb_src_p1;

    logic             sb_clr;
    logic [NREGS-1:0] busy_vec;

    // The held long-latency result wins unless the pipeline was refused last cycle.
    always_comb begin
        hold_grant = hold_vld_p0 && !(starve_p0 && p_valid);
        p_ready    = !hold_grant;
        ll_ready   = !hold_vld_p0 || hold_grant;
        p_acc      = p_valid && p_ready;
        ll_acc     = ll_valid && ll_ready;
        grant_any  = hold_grant || p_acc;
    end

    always_comb begin
        if (hold_grant) begin
            sel_src      = WB_SRC_LL;
            sel_req.rd   = hold_rd_p0;
            sel_req.data = hold_data_p0;
            sel_req.we   = (hold_rd_p0 != '0);
        end else begin
            sel_src      = WB_SRC_PIPE;
            sel_req.rd   = p_rd;
            sel_req.data = p_data;
            sel_req.we   = p_wen && (p_rd != '0);
        end
    end

    // ---- stage p0: long-latency hold register and starvation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_p0 <= 1'b0;
            starve_p0   <= 1'b0;
        end else begin
            if (ll_acc) begin
                hold_vld_p0 <= 1'b1;
            end else if (hold_grant) begin
                hold_vld_p0 <= 1'b0;
            end
            starve_p0 <= p_valid && !p_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (ll_acc) begin
            hold_rd_p0   <= ll_rd;
            hold_data_p0 <= ll_data;
        end
    end

    // ---- stage p1: registered writeback to the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_p1   <= 1'b0;
            retire_p1  <= 1'b0;
            wb_rd_p1   <= '0;
            wb_data_p1 <= '0;
            wb_src_p1  <= WB_SRC_PIPE;
        end else begin
            wb_we_p1  <= grant_any && sel_req.we;
            retire_p1 <= p_acc;
            if (grant_any) begin
                wb_rd_p1   <= sel_req.rd;
                wb_data_p1 <= sel_req.data;
                wb_src_p1  <= sel_src;
            end
        end
    end

    assign wb_we   = wb_we_p1;
    assign retire  = retire_p1;
    assign wb_rd   = wb_rd_p1;
    assign wb_data = wb_data_p1;

    // A pending bit drops on the edge where the register file captures the long-latency write.
    assign sb_clr = wb_we_p1 && (wb_src_p1 == WB_SRC_LL);

    wb_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_valid),
        .set_idx  (iss_rd),
        .clr_en   (sb_clr),
        .clr_idx  (wb_rd_p1),
        .q_idx_a  (q_rs1),
        .q_idx_b  (q_rs2),
        .busy_a   (rs1_busy),
        .busy_b   (rs2_busy),
        .busy_vec (busy_vec)
    );

    pipe_write_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (p_valid && p_ready && p_wen && (p_rd != '0)) |-> !busy_vec[p_rd]);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vectors, multi-cycle sequences and a random run against a reference model.
module tb_writeback_arbiter;
    import wb_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            p_valid;
    logic            p_ready;
    logic [AW-1:0]   p_rd;
    logic [XLEN-1:0] p_data;
    logic            p_wen;
    logic            ll_valid;
    logic            ll_ready;
    logic [AW-1:0]   ll_rd;
    logic [XLEN-1:0] ll_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   q_rs1;
    logic [AW-1:0]   q_rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic            retire;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p_valid  (p_valid),
        .p_ready  (p_ready),
        .p_rd     (p_rd),
        .p_data   (p_data),
        .p_wen    (p_wen),
        .ll_valid (ll_valid),
        .ll_ready (ll_ready),
        .ll_rd    (ll_rd),
        .ll_data  (ll_data),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .q_rs1    (q_rs1),
        .q_rs2    (q_rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_we    (wb_we),
        .retire   (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid   = 1'b0;
        ll_valid  = 1'b0;
        iss_valid = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wen;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_ret;
    } pvec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ll_t;

    pvec_t tbl[6];

    // reference model state
    ll_t         ll_q[$];
    logic [31:0] m_busy;
    logic        m_starve;
    logic        m_we, m_ret, m_src_ll;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    initial begin
        logic p_acc_now, ll_acc_now;
        logic p_hold, ll_hold, hg, e_pr, e_lr;
        int   pick;
        ll_t  e;

        tbl[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 1'b1, 5'd3,  32'hDEADBEEF, 1'b1};
        tbl[1] = '{1'b1, 5'd0,  32'h11111111, 1'b1, 1'b0, 5'd0,  32'h11111111, 1'b1};
        tbl[2] = '{1'b1, 5'd9,  32'hCAFEF00D, 1'b0, 1'b0, 5'd9,  32'hCAFEF00D, 1'b1};
        tbl[3] = '{1'b0, 5'd4,  32'h00000000, 1'b1, 1'b0, 5'd9,  32'hCAFEF00D, 1'b0};
        tbl[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
        tbl[5] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 1'b1, 5'd1,  32'h00000001, 1'b1};

        rst_n = 1'b0;
        idle();
        p_rd = '0; p_data = '0; p_wen = 1'b0;
        ll_rd = '0; ll_data = '0; iss_rd = '0; q_rs1 = '0; q_rs2 = '0;

        // reset state
        #3;
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_retire", retire, 0);
        chk("rst_ll_ready", ll_ready, 1);
        chk("rst_p_ready", p_ready, 1);
        chk("rst_rs1_busy", rs1_busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // pipeline-only vectors
        for (int i = 0; i < 6; i++) begin
            p_valid = tbl[i].v; p_rd = tbl[i].rd; p_data = tbl[i].data; p_wen = tbl[i].wen;
            #2;
            chk("tbl_p_ready", p_ready, 1);
            step();
            chk("tbl_wb_we", wb_we, tbl[i].e_we);
            chk("tbl_wb_rd", wb_rd, tbl[i].e_rd);
            chk("tbl_wb_data", wb_data, tbl[i].e_data);
            chk("tbl_retire", retire, tbl[i].e_ret);
        end
        idle();
        step();

        // contention: both sources held high
        p_valid = 1'b1; p_rd = 5'd20; p_wen = 1'b1; p_data = 32'h5000_0000;
        ll_valid = 1'b1; ll_rd = 5'd10; ll_data = 32'hA000_0000;
        for (int c = 0; c < 7; c++) begin
            if (c >= 1) begin
                chk("cont_wb_we", wb_we, 1);
                if (c % 2 == 1) begin
                    chk("cont_wb_rd_pipe", wb_rd, 20);
                    chk("cont_wb_data_pipe", wb_data, 32'h5000_0000 + (c - 1) / 2);
                    chk("cont_retire_pipe", retire, 1);
                end else begin
                    chk("cont_wb_rd_ll", wb_rd, 10 + c / 2 - 1);
                    chk("cont_wb_data_ll", wb_data, 32'hA000_0000 + c / 2 - 1);
                    chk("cont_retire_ll", retire, 0);
                end
            end
            if (c == 6) idle();
            #2;
            if (c < 6) begin
                chk("cont_p_ready", p_ready, (c % 2 == 0));
                chk("cont_ll_ready", ll_ready, (c == 0) || (c % 2 == 1));
            end
            p_acc_now  = p_valid && p_ready;
            ll_acc_now = ll_valid && ll_ready;
            step();
            if (p_acc_now) p_data = p_data + 1;
            if (ll_acc_now) begin ll_rd = ll_rd + 1; ll_data = ll_data + 1; end
        end
        chk("cont_tail_we", wb_we, 1);
        chk("cont_tail_rd", wb_rd, 13);
        step();
        chk("cont_drain_we", wb_we, 0);
        step();

        // back-to-back long-latency results
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                chk("b2b_wb_we", wb_we, 1);
                chk("b2b_wb_rd", wb_rd, c - 1);
                chk("b2b_wb_data", wb_data, 32'h100 + c - 1);
                chk("b2b_retire", retire, 0);
            end
            if (c < 4) begin
                ll_valid = 1'b1; ll_rd = AW'(c + 1); ll_data = 32'h100 + c + 1;
            end else begin
                ll_valid = 1'b0;
            end
            #2;
            if (c < 4) chk("b2b_ll_ready", ll_ready, 1);
            step();
        end
        chk("b2b_end_we", wb_we, 0);
        step();

        // scoreboard round trip on register 7
        iss_valid = 1'b1; iss_rd = 5'd7; q_rs1 = 5'd7; q_rs2 = 5'd7;
        #2; chk("sb_pre_busy", rs1_busy, 0);
        step();
        iss_valid = 1'b0;
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h12345678;
        #2; chk("sb_set_busy", rs1_busy, 1); chk("sb_ll_ready", ll_ready, 1);
        step();
        ll_valid = 1'b0;
        #2; chk("sb_hold_grant_p_ready", p_ready, 0); chk("sb_busy_t2", rs1_busy, 1);
        step();
        chk("sb_wb_we", wb_we, 1); chk("sb_wb_rd", wb_rd, 7); chk("sb_wb_data", wb_data, 32'h12345678);
        iss_valid = 1'b1; iss_rd = 5'd7;
        #2; chk("sb_busy_wb_cycle", rs1_busy, 1);
        step();
        iss_valid = 1'b0;
        chk("sb_wb_we_off", wb_we, 0);
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'hA5A5A5A5;
        #2; chk("sb_set_wins", rs1_busy, 1);
        step();
        ll_valid = 1'b0;
        step();
        chk("sb_wb2_we", wb_we, 1); chk("sb_wb2_data", wb_data, 32'hA5A5A5A5);
        #2; chk("sb_busy_wb2", rs2_busy, 1);
        step();
        #2; chk("sb_cleared_rs1", rs1_busy, 0); chk("sb_cleared_rs2", rs2_busy, 0);
        step();

        // index 0 never becomes pending
        iss_valid = 1'b1; iss_rd = 5'd0; q_rs1 = 5'd0; q_rs2 = 5'd0;
        step();
        iss_valid = 1'b0;
        #2; chk("q0_rs1", rs1_busy, 0); chk("q0_rs2", rs2_busy, 0);
        step();
        for (int i = 0; i < 32; i++) begin
            q_rs1 = AW'(i); q_rs2 = AW'(31 - i);
            #2; chk("q_all_rs1", rs1_busy, 0); chk("q_all_rs2", rs2_busy, 0);
            step();
        end

        // reset with a result held and a register pending
        iss_valid = 1'b1; iss_rd = 5'd5; q_rs1 = 5'd5;
        p_valid = 1'b1; p_rd = 5'd20; p_wen = 1'b1; p_data = 32'h1;
        ll_valid = 1'b1; ll_rd = 5'd6; ll_data = 32'h66;
        step();
        iss_valid = 1'b0; ll_rd = 5'd8; ll_data = 32'h88;
        #2; chk("rm_p_ready_t1", p_ready, 0);
        step();
        ll_valid = 1'b0;
        chk("rm_wb_we_pre", wb_we, 1);
        #2;
        chk("rm_ll_ready_pre", ll_ready, 0);
        chk("rm_busy_pre", rs1_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rm_wb_we", wb_we, 0);
        chk("rm_ll_ready", ll_ready, 1);
        chk("rm_busy", rs1_busy, 0);
        chk("rm_wb_rd", wb_rd, 0);
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rm_no_write", wb_we, 0);
            chk("rm_no_retire", retire, 0);
            step();
        end
        #2; chk("rm_busy_after", rs1_busy, 0);
        step();

        // random run against the reference model
        m_busy = '0; m_starve = 1'b0; m_we = 1'b0; m_ret = 1'b0; m_src_ll = 1'b0;
        m_rd = '0; m_data = '0; ll_q.delete();
        p_hold = 1'b0; ll_hold = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_wb_we", wb_we, m_we);
            chk("rnd_wb_rd", wb_rd, m_rd);
            chk("rnd_wb_data", wb_data, m_data);
            chk("rnd_retire", retire, m_ret);
            if (!p_hold) begin
                p_valid = ($urandom % 3) != 0;
                pick    = $urandom % 17;
                p_rd    = (pick == 0) ? 5'd0 : AW'(15 + pick);
                p_data  = $urandom;
                p_wen   = ($urandom % 4) != 0;
            end
            if (!ll_hold) begin
                ll_valid = $urandom % 2;
                ll_rd    = AW'($urandom % 16);
                ll_data  = $urandom;
            end
            iss_valid = ($urandom % 3) == 0;
            iss_rd    = AW'($urandom % 16);
            q_rs1     = AW'($urandom % 32);
            q_rs2     = AW'($urandom % 32);
            #2;
            hg   = (ll_q.size() != 0) && !(m_starve && p_valid);
            e_pr = !hg;
            e_lr = (ll_q.size() == 0) || hg;
            chk("rnd_p_ready", p_ready, e_pr);
            chk("rnd_ll_ready", ll_ready, e_lr);
            chk("rnd_rs1_busy", rs1_busy, m_busy[q_rs1]);
            chk("rnd_rs2_busy", rs2_busy, m_busy[q_rs2]);

            if (m_we && m_src_ll) m_busy[m_rd] = 1'b0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            if (hg) begin
                e = ll_q.pop_front();
                m_rd = e.rd; m_data = e.data; m_we = (e.rd != 0); m_src_ll = 1'b1; m_ret = 1'b0;
            end else if (p_valid) begin
                m_rd = p_rd; m_data = p_data; m_we = p_wen && (p_rd != 0); m_src_ll = 1'b0; m_ret = 1'b1;
            end else begin
                m_we = 1'b0; m_ret = 1'b0;
            end
            if (ll_valid && e_lr) ll_q.push_back('{ll_rd, ll_data});
            m_starve = p_valid && !e_pr;
            p_hold   = p_valid && !e_pr;
            ll_hold  = ll_valid && !e_lr;
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
